// File: rtl/bram_96x1024.sv
// True dual-port block RAM with write-first own-port reads and read-old cross-port reads.
// Define BRAM_OUT_REG_EN to add a second output register stage per port (read latency 2).
module bram_96x1024 #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  input  logic                  enb,
  input  logic                  web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth] = '{default: '0};
  logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;

  // Port A is written last so it wins a same-address write/write collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (enb && web) mem[addrb] <= dinb;
      if (ena && wea) mem[addra] <= dina;
    end
  end

  // Reads sample the array before this edge's writes land, giving old data across ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      if (ena) rd_a_q <= wea ? dina : mem[addra];
      if (enb) rd_b_q <= web ? dinb : mem[addrb];
    end
  end

`ifdef BRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_a_q, out_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      if (ena) out_a_q <= rd_a_q;
      if (enb) out_b_q <= rd_b_q;
    end
  end

  assign douta = out_a_q;
  assign doutb = out_b_q;
`else
  assign douta = rd_a_q;
  assign doutb = rd_b_q;
`endif

endmodule

// File: tb/tb_bram_96x1024.sv
// Self-checking bench for bram_96x1024: directed vector table, reset/enable sequences,
// and randomized dual-port traffic checked against an array-based reference model.
module tb_bram_96x1024;

`ifdef BRAM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  localparam logic [95:0] C1   = 96'h1234_5678_9ABC_DEF0_1111_2222;
  localparam logic [95:0] Ones = {96{1'b1}};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wea, enb, web;
  logic [9:0]  addra, addrb;
  logic [95:0] dina, dinb, douta, doutb;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: plain memory array plus the last two enabled read results per port.
  logic [95:0] ref_mem [1024];
  logic [95:0] ha1 = '0, ha2 = '0, hb1 = '0, hb2 = '0;

  typedef struct {
    logic        ea, wa;
    logic [9:0]  aa;
    logic [95:0] da;
    logic        eb, wb;
    logic [9:0]  ab;
    logic [95:0] db;
    logic        ca, cb;
    logic [95:0] xa, xb;
  } vec_t;

  vec_t tbl [10];

  bram_96x1024 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .enb   (enb),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_edge();
    logic [95:0] ra, rb;
    if (!rst_n) return;
    ra = wea ? dina : ref_mem[addra];
    rb = web ? dinb : ref_mem[addrb];
    if (ena) begin ha2 = ha1; ha1 = ra; end
    if (enb) begin hb2 = hb1; hb1 = rb; end
    if (enb && web) ref_mem[addrb] = dinb;
    if (ena && wea) ref_mem[addra] = dina;
  endtask

  task automatic step(input logic ea, input logic wa, input logic [9:0] aa,
                      input logic [95:0] da, input logic eb, input logic wb,
                      input logic [9:0] ab, input logic [95:0] db);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_douta"}, douta, (Lat == 1) ? ha1 : ha2);
    check({tag, "_doutb"}, doutb, (Lat == 1) ? hb1 : hb2);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [9:0]  ra, rb;
    logic [95:0] v;

    tbl[0] = '{1, 1, 10'd5,    C1,    0, 0, 10'd0,    '0,    1, 0, C1,    '0};
    tbl[1] = '{0, 0, 10'd0,    '0,    1, 0, 10'd5,    '0,    1, 1, C1,    C1};
    tbl[2] = '{1, 1, 10'd7,    96'hA, 0, 0, 10'd0,    '0,    1, 0, 96'hA, '0};
    tbl[3] = '{1, 1, 10'd7,    96'hB, 1, 0, 10'd7,    '0,    1, 1, 96'hB, 96'hA};
    tbl[4] = '{0, 0, 10'd0,    '0,    1, 0, 10'd7,    '0,    1, 1, 96'hB, 96'hB};
    tbl[5] = '{1, 1, 10'd9,    96'h1, 1, 1, 10'd9,    96'h2, 1, 1, 96'h1, 96'h2};
    tbl[6] = '{1, 0, 10'd9,    '0,    1, 0, 10'd9,    '0,    1, 1, 96'h1, 96'h1};
    tbl[7] = '{1, 1, 10'd1023, Ones,  1, 1, 10'd0,    '0,    1, 1, Ones,  '0};
    tbl[8] = '{1, 0, 10'd0,    '0,    1, 0, 10'd1023, '0,    1, 1, '0,    Ones};
    tbl[9] = '{1, 0, 10'd5,    '0,    1, 0, 10'd1023, '0,    1, 1, C1,    Ones};

    rst_n = 1'b0;
    ena = 0; wea = 0; addra = '0; dina = '0;
    enb = 0; web = 0; addrb = '0; dinb = '0;
    #1;
    check("reset_douta", douta, '0);
    check("reset_doutb", doutb, '0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].ea, tbl[i].wa, tbl[i].aa, tbl[i].da, tbl[i].eb, tbl[i].wb, tbl[i].ab, tbl[i].db);
      for (int k = 1; k < Lat; k++)
        step(tbl[i].ea, 1'b0, tbl[i].aa, '0, tbl[i].eb, 1'b0, tbl[i].ab, '0);
      if (tbl[i].ca) check($sformatf("vec%0d_douta", i), douta, tbl[i].xa);
      if (tbl[i].cb) check($sformatf("vec%0d_doutb", i), doutb, tbl[i].xb);
    end

    // Asynchronous reset while both outputs are nonzero, with writes attempted during reset.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_douta", douta, '0);
    check("async_rst_doutb", doutb, '0);
    ha1 = '0; ha2 = '0; hb1 = '0; hb2 = '0;
    step(1, 1, 10'd5, 96'hDEAD, 1, 1, 10'd1023, 96'hBEEF);
    step(1, 1, 10'd5, 96'hDEAD, 1, 1, 10'd1023, 96'hBEEF);
    check("in_rst_douta", douta, '0);
    check("in_rst_doutb", doutb, '0);
    rst_n = 1'b1;
    for (int k = 0; k < Lat; k++) step(1, 0, 10'd5, '0, 1, 0, 10'd1023, '0);
    check("post_rst_mem5", douta, C1);
    check("post_rst_mem1023", doutb, Ones);

    // Enable hold: output and memory untouched while ena=0, even with wea=1.
    step(1, 1, 10'd3, 96'h5A5A, 0, 0, 0, 0);
    for (int k = 0; k < Lat; k++) step(1, 0, 10'd3, '0, 0, 0, 0, 0);
    check("hold_read", douta, 96'h5A5A);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, (k == 1) ? 10'd8 : 10'd3, 96'hFFFF_0000, 0, 0, 0, 0);
      check($sformatf("hold_%0d", k), douta, 96'h5A5A);
    end
    for (int k = 0; k < Lat; k++) step(1, 0, 10'd3, '0, 0, 0, 0, 0);
    check("hold_mem_intact", douta, 96'h5A5A);

    for (int i = 0; i < 16; i++) begin
      step(1, 1, 10'(i), rnd96(), 0, 0, 0, 0);
      check_model("prefill");
    end

    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      rb = ($urandom_range(0, 9) == 0) ? 10'd1023 : 10'($urandom_range(0, 15));
      v  = rnd96();
      step($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, ra, v,
           $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, rb, rnd96());
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
